// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop clock divider with handshaked divisor change; define CLK_DIV_CTRL_ERR_EN to reject div_val=0 via div_err
module clk_div_ctrl #(
    parameter int unsigned N_INIT = 4
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       run,
    input  logic       div_req,
    input  logic [3:0] div_val,
    output logic       div_ack,
    output logic       clk_out,
    output logic       clk_en,
    output logic [1:0] state
`ifdef CLK_DIV_CTRL_ERR_EN
    ,
    output logic       div_err
`endif
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOPPING = 2'b10} state_t;
    state_t cur, nxt;
    logic [3:0] n, n_nxt, count, count_nxt;
    logic out_nxt, en_nxt, ack_nxt, wrap, fall, take, apply, zero;
    assign state = cur;
    always_comb begin
        wrap      = count == n - 4'd1;
        fall      = wrap && clk_out;
        take      = div_req && !div_ack;
        zero      = div_val == 4'd0;
        nxt       = cur;
        count_nxt = 4'd0;
        out_nxt   = 1'b0;
        en_nxt    = 1'b0;
        apply     = 1'b0;
        if (cur == IDLE) begin
            nxt   = run ? RUN : IDLE;
            apply = take;
        end else begin
            count_nxt = wrap ? 4'd0 : count + 4'd1;
            out_nxt   = wrap ? ~clk_out : clk_out;
            en_nxt    = wrap && !clk_out;
            apply     = fall && take;
            nxt       = run ? RUN : (cur == STOPPING && fall) ? IDLE : STOPPING;
        end
        ack_nxt = apply;
`ifdef CLK_DIV_CTRL_ERR_EN
        n_nxt = (apply && !zero) ? div_val : n;
`else
        n_nxt = apply ? (zero ? 4'd1 : div_val) : n;
`endif
    end
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cur     <= IDLE;
            n       <= 4'(N_INIT);
            count   <= 4'd0;
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
            div_ack <= 1'b0;
        end else begin
            cur     <= nxt;
            n       <= n_nxt;
            count   <= count_nxt;
            clk_out <= out_nxt;
            clk_en  <= en_nxt;
            div_ack <= ack_nxt;
        end
    end
`ifdef CLK_DIV_CTRL_ERR_EN
    always_ff @(posedge clk_in) begin
        div_err <= !reset && apply && zero;
    end
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed checks of run/stop, divisor handshake, zero divisor and reset
module tb_clk_div_ctrl;
    logic       clk_in = 1'b0;
    logic       reset = 1'b1, run = 1'b0, div_req = 1'b0;
    logic [3:0] div_val = 4'd0;
    logic       div_ack, clk_out, clk_en;
    logic [1:0] state;
`ifdef CLK_DIV_CTRL_ERR_EN
    logic       div_err;
`endif
    int total = 0, bad = 0;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(.N_INIT(4)) dut (
        .clk_in(clk_in),
        .reset(reset),
        .run(run),
        .div_req(div_req),
        .div_val(div_val),
        .div_ack(div_ack),
        .clk_out(clk_out),
        .clk_en(clk_en),
        .state(state)
`ifdef CLK_DIV_CTRL_ERR_EN
        ,
        .div_err(div_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_state", 32'(state), 0);
        chk("rst_out", 32'(clk_out), 0);
        chk("rst_en", 32'(clk_en), 0);
        chk("rst_ack", 32'(div_ack), 0);
        reset = 1'b0;
        run = 1'b1;
        tick;
        chk("run_entry", 32'(state), 1);
        chk("entry_out", 32'(clk_out), 0);
        for (int k = 1; k <= 21; k++) begin
            tick;
            chk("n4_out", 32'(clk_out), 32'((k / 4) % 2));
            chk("n4_en", 32'(clk_en), 32'(k % 8 == 4));
        end
        div_req = 1'b1;
        div_val = 4'd2;
        tick;
        chk("req_wait0", 32'(div_ack), 0);
        tick;
        chk("req_wait1", 32'(div_ack), 0);
        tick;
        chk("req_ack", 32'(div_ack), 1);
        chk("req_fall", 32'(clk_out), 0);
        tick;
        chk("req_no_reack", 32'(div_ack), 0);
        chk("n2_out1", 32'(clk_out), 0);
        div_req = 1'b0;
        for (int j = 2; j <= 8; j++) begin
            tick;
            chk("n2_out", 32'(clk_out), 32'((j / 2) % 2));
            chk("n2_en", 32'(clk_en), 32'(j % 4 == 2));
        end
        div_req = 1'b1;
        div_val = 4'd3;
        for (int j = 9; j <= 11; j++) begin
            tick;
            chk("n3_wait", 32'(div_ack), 0);
        end
        tick;
        chk("n3_ack", 32'(div_ack), 1);
        chk("n3_fall", 32'(clk_out), 0);
        div_req = 1'b0;
        tick;
        tick;
        chk("n3_low", 32'(clk_out), 0);
        run = 1'b0;
        tick;
        chk("stop_state", 32'(state), 2);
        chk("stop_rise", 32'(clk_out), 1);
        chk("stop_en", 32'(clk_en), 1);
        tick;
        tick;
        chk("stop_high", 32'(clk_out), 1);
        chk("stop_state2", 32'(state), 2);
        tick;
        chk("stop_idle", 32'(state), 0);
        chk("stop_low", 32'(clk_out), 0);
        tick;
        chk("idle_hold", 32'(state), 0);
        div_req = 1'b1;
        div_val = 4'd7;
        tick;
        chk("idle_ack", 32'(div_ack), 1);
        chk("idle_state", 32'(state), 0);
        tick;
        chk("idle_no_reack", 32'(div_ack), 0);
        div_req = 1'b0;
        run = 1'b1;
        tick;
        chk("n7_entry", 32'(state), 1);
        for (int k = 1; k <= 28; k++) begin
            tick;
            chk("n7_out", 32'(clk_out), 32'((k / 7) % 2));
            chk("n7_en", 32'(clk_en), 32'(k % 14 == 7));
        end
        run = 1'b0;
        tick;
        chk("restop_state", 32'(state), 2);
        run = 1'b1;
        tick;
        chk("rerun_state", 32'(state), 1);
        for (int k = 31; k <= 35; k++) begin
            tick;
            chk("rerun_out", 32'(clk_out), 32'((k / 7) % 2));
        end
        chk("rerun_en", 32'(clk_en), 1);
        div_req = 1'b1;
        div_val = 4'd0;
        for (int k = 36; k <= 41; k++) begin
            tick;
            chk("zero_wait", 32'(div_ack), 0);
        end
        tick;
        chk("zero_ack", 32'(div_ack), 1);
        chk("zero_fall", 32'(clk_out), 0);
`ifdef CLK_DIV_CTRL_ERR_EN
        chk("zero_err", 32'(div_err), 1);
        div_req = 1'b0;
        for (int k = 43; k <= 49; k++) begin
            tick;
            chk("zero_keep_out", 32'(clk_out), 32'(k == 49));
            if (k == 43) chk("zero_err_clr", 32'(div_err), 0);
        end
`else
        div_req = 1'b0;
        for (int k = 43; k <= 46; k++) begin
            tick;
            chk("n1_out", 32'(clk_out), 32'(k % 2));
            chk("n1_en", 32'(clk_en), 32'(k % 2));
        end
`endif
        div_req = 1'b1;
        div_val = 4'd5;
        tick;
        chk("pend_ack", 32'(div_ack), 0);
        reset = 1'b1;
        tick;
        chk("rst2_ack", 32'(div_ack), 0);
        chk("rst2_state", 32'(state), 0);
        chk("rst2_out", 32'(clk_out), 0);
        chk("rst2_en", 32'(clk_en), 0);
        reset = 1'b0;
        div_req = 1'b0;
        run = 1'b1;
        tick;
        chk("rst2_entry", 32'(state), 1);
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("rst2_n4_out", 32'(clk_out), 32'((k / 4) % 2));
            chk("rst2_no_ack", 32'(div_ack), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
